// File: rtl/midi_note_parser.sv
// MIDI byte parser: running status, channel filter, and a monophonic
// last-note-priority gate/key/volume control word for the waveform generator.
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter logic       OMNI    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] note_vol,
  output logic        note_update
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D1 = 2'd1;
  localparam logic [1:0] WAIT_D2 = 2'd2;
  localparam logic [1:0] SYSEX   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  run_status_q, run_status_d;
  logic        rs_valid_q, rs_valid_d;
  logic [6:0]  key_q, key_d;
  logic [15:0] note_vol_q, note_vol_d;
  logic        note_update_q, note_update_d;

  logic        st_rt, st_sysex, st_sys, st_chan;
  logic        msg_done;
  logic [6:0]  vel;
  logic [3:0]  msg_type;
  logic        chan_ok, accept, note_on;

  assign msg_type = run_status_q[7:4];
  assign chan_ok  = OMNI || (run_status_q[3:0] == CHANNEL);

  // Mutually exclusive status byte classes
  assign st_rt    = (rx_data[7:3] == 5'b11111);
  assign st_sysex = (rx_data == 8'hF0);
  assign st_sys   = (rx_data[7:4] == 4'hF) && !st_rt && !st_sysex;
  assign st_chan  = (rx_data[7:4] != 4'hF);

  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    rs_valid_d   = rs_valid_q;
    key_d        = key_q;
    msg_done     = 1'b0;
    vel          = 7'd0;
    if (rx_valid) begin
      if (rx_data[7]) begin
        unique case (1'b1)
          st_rt: begin
          end
          st_sysex: begin
            rs_valid_d = 1'b0;
            state_d    = SYSEX;
          end
          st_sys: begin
            rs_valid_d = 1'b0;
            state_d    = IDLE;
          end
          st_chan: begin
            run_status_d = rx_data;
            rs_valid_d   = 1'b1;
            state_d      = WAIT_D1;
          end
          default: begin
          end
        endcase
      end else begin
        unique case (state_q)
          WAIT_D1: begin
            key_d = rx_data[6:0];
            if (msg_type == 4'hC || msg_type == 4'hD) begin
              msg_done = 1'b1;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_done = 1'b1;
            vel      = rx_data[6:0];
            state_d  = WAIT_D1;
          end
          IDLE, SYSEX: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Only two-byte 0x8/0x9 messages complete from WAIT_D2, so key_q holds the key
  assign accept  = msg_done && rs_valid_q && chan_ok &&
                   (msg_type == 4'h8 || msg_type == 4'h9);
  assign note_on = (msg_type == 4'h9) && (vel != 7'd0);

  always_comb begin
    note_vol_d    = note_vol_q;
    note_update_d = 1'b0;
    if (accept) begin
      if (note_on) begin
        note_vol_d    = {1'b1, key_q, vel, vel[6]};
        note_update_d = 1'b1;
      end else if (note_vol_q[15] && note_vol_q[14:8] == key_q) begin
        note_vol_d    = {1'b0, key_q, 8'h00};
        note_update_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      run_status_q  <= 8'h00;
      rs_valid_q    <= 1'b0;
      key_q         <= 7'd0;
      note_vol_q    <= 16'h0000;
      note_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_status_q  <= run_status_d;
      rs_valid_q    <= rs_valid_d;
      key_q         <= key_d;
      note_vol_q    <= note_vol_d;
      note_update_q <= note_update_d;
    end
  end

  assign note_vol    = note_vol_q;
  assign note_update = note_update_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser: one channel-0 instance and one
// OMNI instance fed the same byte stream.
module tb_midi_note_parser;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] nv0, nv1;
  logic        nu0, nu1;

  int tests;
  int fails;
  int pulses;

  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .note_vol   (nv0),
    .note_update(nu0)
  );

  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_omni (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .note_vol   (nv1),
    .note_update(nu1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (nu0) pulses++;
  end

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    pulses   = 0;
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #12;
    check("reset_nv", nv0, 16'h0000);
    check("reset_nu", {15'd0, nu0}, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    send(8'h40);
    idle(2);
    check("orphan_data_pulses", pulses[15:0], 16'd0);
    check("orphan_data_nv", nv0, 16'h0000);

    pulses = 0;
    send(8'h90); send(8'h3C); send(8'h7F);
    idle(1);
    check("basic_on_nv", nv0, 16'hBCFF);
    check("basic_on_nu", {15'd0, nu0}, 16'd1);
    idle(1);
    check("basic_on_nu_low", {15'd0, nu0}, 16'd0);
    check("basic_on_pulses", pulses[15:0], 16'd1);

    pulses = 0;
    send(8'h80); send(8'h3C); send(8'h00);
    idle(2);
    check("basic_off_nv", nv0, 16'h3C00);
    check("basic_off_pulses", pulses[15:0], 16'd1);

    pulses = 0;
    send(8'h90); send(8'h40); send(8'h40); send(8'h40);
    check("rs_first_nv", nv0, 16'hC081);
    check("rs_first_nu", {15'd0, nu0}, 16'd1);
    send(8'h00);
    idle(2);
    check("rs_second_nv", nv0, 16'h4000);
    check("rs_pulses", pulses[15:0], 16'd2);

    pulses = 0;
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    idle(2);
    check("rt_nv", nv0, 16'hBCC9);
    check("rt_pulses", pulses[15:0], 16'd1);

    pulses = 0;
    send(8'h90); send(8'h3E); send(8'h7F);
    send(8'h80); send(8'h3C); send(8'h00);
    idle(2);
    check("lastnote_nv", nv0, 16'hBEFF);
    check("lastnote_pulses", pulses[15:0], 16'd1);

    pulses = 0;
    send(8'h91); send(8'h3C); send(8'h7F);
    idle(2);
    check("chan_filter_nv", nv0, 16'hBEFF);
    check("chan_filter_pulses", pulses[15:0], 16'd0);
    check("omni_nv", nv1, 16'hBCFF);

    pulses = 0;
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7);
    send(8'h3C); send(8'h7F);
    idle(2);
    check("sysex_nv", nv0, 16'hBEFF);
    check("sysex_pulses", pulses[15:0], 16'd0);

    pulses = 0;
    send(8'hC0); send(8'h05); send(8'h90); send(8'h30); send(8'h10);
    idle(2);
    check("prog_then_on_nv", nv0, 16'hB020);
    check("prog_then_on_pulses", pulses[15:0], 16'd1);

    send(8'h90); send(8'h3C);
    idle(1);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_nv", nv0, 16'h0000);
    check("async_reset_nu", {15'd0, nu0}, 16'd0);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    send(8'h40); send(8'h7F);
    idle(2);
    check("post_reset_nv", nv0, 16'h0000);
    check("post_reset_pulses", pulses[15:0], 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
